// File: rtl/char_deserializer.sv
// 8N1 serial receiver: 2-flop sync, mid-bit sampling, LSB-first assembly into a one-entry valid/ready output register.
// Result visible one cycle after the stop sample; the line never stalls, so a full register drops new bytes with an overrun pulse.
module char_deserializer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] char_out,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      char_q, char_d;
  logic            vld_q, vld_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            sync1_q, sync2_q;
  logic            rxs;

  assign rxs = sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      char_q  <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      char_q  <= char_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    char_d  = char_q;
    vld_d   = vld_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    // Consumer transfer; a simultaneous load below overrides the clear.
    if (vld_q && char_ready) begin
      vld_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF) begin
          if (!rxs) begin
            state_d = DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          shift_d[idx_q] = rxs;
          cnt_d          = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (rxs) begin
            if (!vld_q || char_ready) begin
              char_d = shift_q;
              vld_d  = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            shift_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign char_out   = char_q;
  assign char_valid = vld_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_char_deserializer.sv
// Directed bench for char_deserializer at CLKS_PER_BIT=16.
module tb_char_deserializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] char_out;
  logic       char_valid;
  logic       char_ready;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int rise_cyc = -1;
  logic prev_v = 1'b0;
  logic [7:0] xfer_q[$];

  char_deserializer #(.CLKS_PER_BIT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Observe outputs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (char_valid && !prev_v && rise_cyc < 0) rise_cyc = cyc;
    prev_v = char_valid;
    if (char_valid && char_ready) xfer_q.push_back(char_out);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame, 160 cycles. rdy_pulse raises char_ready only for the stop-sample edge;
  // rst_k >= 0 drops rst_n for the edge that ends frame cycle rst_k.
  task automatic send(input logic [7:0] d, input logic stop, input bit rdy_pulse, input int rst_k);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int k = 0; k < 160; k++) begin
      rx = fr[k / 16];
      if (rdy_pulse) char_ready = (k == 154);
      rst_n = (k == rst_k) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    rx    = 1'b1;
    if (rdy_pulse) char_ready = 1'b0;
  endtask

  int t0;

  initial begin
    rx = 1'b1;
    char_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_char_out", 32'(char_out), 32'h00);
    chk("rst_valid", 32'(char_valid), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    idle(5);

    // Basic receive of 'a'
    rise_cyc = -1;
    t0 = cyc;
    send(8'h61, 1'b1, 1'b0, -1);
    chk("basic_char", 32'(char_out), 32'h61);
    chk("basic_valid", 32'(char_valid), 32'h1);
    chk("basic_latency", 32'(rise_cyc), 32'(t0 + 155));
    chk("basic_ferr", 32'(ferr_cnt), 32'd0);
    chk("basic_ovr", 32'(ovr_cnt), 32'd0);
    char_ready = 1'b1;
    idle(1);
    char_ready = 1'b0;
    chk("basic_consumed", 32'(char_valid), 32'h0);

    // Start glitch, then 'z'
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(20);
    chk("glitch_valid", 32'(char_valid), 32'h0);
    chk("glitch_ferr", 32'(ferr_cnt), 32'd0);
    send(8'h7A, 1'b1, 1'b0, -1);
    chk("glitch_next_char", 32'(char_out), 32'h7A);
    chk("glitch_next_valid", 32'(char_valid), 32'h1);
    char_ready = 1'b1;
    idle(1);
    char_ready = 1'b0;

    // Framing error
    send(8'h41, 1'b0, 1'b0, -1);
    idle(20);
    chk("ferr_pulse_cycles", 32'(ferr_cnt), 32'd1);
    chk("ferr_valid", 32'(char_valid), 32'h0);
    chk("ferr_char_kept", 32'(char_out), 32'h7A);

    // Overrun, then simultaneous transfer and load
    send(8'h31, 1'b1, 1'b0, -1);
    send(8'h32, 1'b1, 1'b0, -1);
    chk("ovr_pulse_cycles", 32'(ovr_cnt), 32'd1);
    chk("ovr_char_kept", 32'(char_out), 32'h31);
    chk("ovr_valid", 32'(char_valid), 32'h1);
    xfer_q.delete();
    send(8'h32, 1'b1, 1'b1, -1);
    chk("swap_char", 32'(char_out), 32'h32);
    chk("swap_valid", 32'(char_valid), 32'h1);
    chk("swap_no_ovr", 32'(ovr_cnt), 32'd1);
    chk("swap_xfer_cnt", 32'(xfer_q.size()), 32'd1);
    chk("swap_xfer_old", 32'(xfer_q[0]), 32'h31);
    char_ready = 1'b1;
    idle(1);

    // Back-to-back "az{" with ready held high
    xfer_q.delete();
    send(8'h61, 1'b1, 1'b0, -1);
    send(8'h7A, 1'b1, 1'b0, -1);
    send(8'h7B, 1'b1, 1'b0, -1);
    idle(3);
    char_ready = 1'b0;
    chk("b2b_count", 32'(xfer_q.size()), 32'd3);
    chk("b2b_0", 32'(xfer_q[0]), 32'h61);
    chk("b2b_1", 32'(xfer_q[1]), 32'h7A);
    chk("b2b_2", 32'(xfer_q[2]), 32'h7B);
    chk("b2b_valid_after", 32'(char_valid), 32'h0);

    // Reset during the bit-4 sample while 0x55 is held
    send(8'h55, 1'b1, 1'b0, -1);
    chk("hold55_char", 32'(char_out), 32'h55);
    send(8'hF0, 1'b1, 1'b0, 90);
    idle(10);
    chk("rstmid_valid", 32'(char_valid), 32'h0);
    chk("rstmid_char", 32'(char_out), 32'h00);
    chk("rstmid_ferr", 32'(ferr_cnt), 32'd1);
    send(8'h62, 1'b1, 1'b0, -1);
    chk("rstmid_next_char", 32'(char_out), 32'h62);
    chk("rstmid_next_valid", 32'(char_valid), 32'h1);
    chk("final_ovr", 32'(ovr_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/char_deserializer.md
# char_deserializer

Serial character receiver placed directly upstream of the case-conversion stage. It takes an asynchronous 8N1 serial line and assembles the bits LSB-first into one byte. Each completed byte is presented on `char_out[7:0]`, which drives the converter's A0..A7 inputs bit for bit (char_out[0] to A0, and so on). A one-entry output register with a valid/ready handshake decouples reception from the consumer. Framing errors and overruns are flagged.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit period. Must be even and at least 4.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `rx`, input, 1: serial line. Asynchronous to `clk`. Idles high.
- `char_out`, output, 8: received character, with bit 0 being the first data bit received.
- `char_valid`, output, 1: `char_out` holds an unconsumed character.
- `char_ready`, input, 1: the consumer accepts `char_out` in this cycle.
- `frame_err`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `overrun`, output, 1: one-cycle pulse when a new character is dropped because the output register is full.

## Operation

- `rx` passes through a 2-flop synchronizer. Both flops reset to 1. `rxs` below means the synchronized value.
- The bit counter `cnt` has width clog2(CLKS_PER_BIT). The bit index `idx` is 3 bits.
- FSM states and transitions:
  - IDLE: if `rxs`=0, go to START with `cnt`=0.
  - START: when `cnt` = CLKS_PER_BIT/2−1, this is the mid-bit sample.
    - If `rxs`=0, go to DATA with `cnt`=0 and `idx`=0.
    - If `rxs`=1, treat it as a glitch and return to IDLE. No flag is raised.
    - Otherwise increment `cnt`.
  - DATA: when `cnt` = CLKS_PER_BIT−1, shift `rxs` into the shift register at bit `idx` (LSB-first) and reset `cnt`.
    - If `idx`=7, go to STOP. Otherwise increment `idx`.
  - STOP: when `cnt` = CLKS_PER_BIT−1, sample `rxs`, then return to IDLE.
    - `rxs`=1: the character is complete. Apply the load rule below.
    - `rxs`=0: pulse `frame_err` for one cycle. The shift register is discarded and `char_out` and `char_valid` are unchanged.
- Load rule, on completion:
  - If `char_valid`=0, or `char_valid`=1 with `char_ready`=1 in the same cycle: load `char_out` and set `char_valid`=1.
  - If `char_valid`=1 and `char_ready`=0: drop the new byte, pulse `overrun`, and keep the old byte.
- Handshake:
  - A transfer occurs on any cycle where `char_valid`=1 and `char_ready`=1.
  - If there is no simultaneous load, `char_valid` goes to 0 on the next edge.
  - `char_out` is held stable while `char_valid`=1 and no transfer occurs.
  - `char_ready` while `char_valid`=0 has no effect.
- The receiver never stalls. The serial stream continues regardless of the consumer.

## Timing

- Reset (`rst_n`=0 at an edge):
  - The FSM goes to IDLE; `cnt`, `idx` and the shift register clear to 0.
  - The synchronizer flops go to 1.
  - `char_out`=8'h00, `char_valid`=0, `frame_err`=0, `overrun`=0.
- Reset mid-frame aborts the frame with no flag. A held character is lost.
- `rxs` lags `rx` by 2 cycles.
- The START sample occurs in the CLKS_PER_BIT/2-th cycle spent in START.
- Data samples follow every CLKS_PER_BIT cycles. The stop sample comes CLKS_PER_BIT cycles after the bit-7 sample.
- The stop sample is 8 + 9×16 = 152 cycles after START entry when CLKS_PER_BIT=16.
- `char_valid`, `frame_err` and `overrun` update on the edge that performs the stop sample. They are visible in the following cycle.
- IDLE is re-entered right after the stop sample, so back-to-back frames (next start bit immediately after the stop bit) are received.
- Outputs are registered. There is no combinational path from `rx` or `char_ready` to any output.

## Test plan

- **Basic receive:** CLKS_PER_BIT=16; send 0x61 ('a') 8N1 with `char_ready`=0. Expect `char_out`=8'h61 and `char_valid`=1, 152 cycles after START entry (plus the sync delay). `frame_err` and `overrun` stay 0. Raise `char_ready` for 1 cycle, then expect `char_valid`=0.
- **Start glitch:** pull `rx` low for 3 cycles, then high. Expect a return to IDLE with no `char_valid` and no `frame_err`. A following frame 0x7A is received correctly.
- **Framing error:** send 0x41 with the stop bit low. Expect `frame_err` high for exactly 1 cycle, `char_valid` still 0, and `char_out` unchanged.
- **Overrun:** receive 0x31 with `char_ready`=0, then 0x32. Expect `overrun` as a 1-cycle pulse and `char_out` still 8'h31. Repeat with `char_ready`=1 held during the second stop sample: expect `char_out`=8'h32, `char_valid`=1, and no `overrun`.
- **Back-to-back:** stream "az{" (0x61, 0x7A, 0x7B) with no idle gap and `char_ready`=1. Expect three valid pulses carrying those bytes in order.
- **Reset mid-frame:** assert `rst_n`=0 for 1 cycle during the bit-4 sample, with `char_valid` holding 0x55. Expect `char_valid`=0, `char_out`=8'h00, and the FSM in IDLE. The next full frame 0x62 is received correctly.
